// File: rtl/data_mem.sv
// Byte-addressable RV32I data memory: combinational sized/extended loads, lane-masked stores on clk.
// Misaligned-access trapping (sticky flag + first fault address) is built only with DMEM_MISALIGN_TRAP_EN.
module data_mem #(
  parameter int DEPTH = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Addr,
  input  logic [31:0] WriteData,
  input  logic        MemWrite,
  input  logic        MemRead,
  input  logic [2:0]  funct3,
  input  logic        ErrClear,
  output logic [31:0] ReadData,
  output logic        MisalignErr,
  output logic [31:0] ErrAddr
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  logic [31:0]   r_mem [DEPTH];
  logic [AW-1:0] w_idx;
  logic [31:0]   w_word;
  logic [7:0]    w_byte;
  logic [15:0]   w_half;
  logic          w_ld_mis;
  logic          w_st_mis;
  logic [3:0]    w_be;
  logic [31:0]   w_wdat;

  // Upper address bits fall away, so the array aliases every 4*DEPTH bytes.
  assign w_idx  = Addr[AW+1:2];
  assign w_word = r_mem[w_idx];

`ifdef DMEM_MISALIGN_TRAP_EN
  logic        w_is_half_ld;
  logic        w_is_half_st;
  logic        w_is_word;
  logic        w_fault;
  logic        r_err;
  logic [31:0] r_err_addr;
  logic        w_unused_ok;

  assign w_is_half_ld = (funct3 == F3_H) || (funct3 == F3_HU);
  assign w_is_half_st = (funct3 == F3_H);
  assign w_is_word    = (funct3 == F3_W);

  // A combined read+write cycle is a store, so load rules only apply when MemWrite is low.
  assign w_ld_mis = MemRead && !MemWrite &&
                    ((w_is_half_ld && Addr[0]) || (w_is_word && (Addr[1:0] != 2'b00)));
  assign w_st_mis = MemWrite &&
                    ((w_is_half_st && Addr[0]) || (w_is_word && (Addr[1:0] != 2'b00)));
  assign w_fault  = w_ld_mis || w_st_mis;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_err      <= 1'b0;
      r_err_addr <= 32'h0;
    end else if (w_fault) begin
      r_err <= 1'b1;
      if (!r_err || ErrClear) r_err_addr <= Addr;
    end else if (ErrClear) begin
      r_err <= 1'b0;
    end
  end

  assign MisalignErr = r_err;
  assign ErrAddr     = r_err_addr;
  assign w_unused_ok = ^Addr;
`else
  logic w_unused_ok;

  // Lane selection below already ignores the sub-size address bits, which is the force-align behaviour.
  assign w_ld_mis    = 1'b0;
  assign w_st_mis    = 1'b0;
  assign MisalignErr = 1'b0;
  assign ErrAddr     = 32'h0;
  assign w_unused_ok = ^{Addr, MemRead, ErrClear};
`endif

  always_comb begin
    w_be   = 4'b0000;
    w_wdat = 32'h0;
    case (funct3)
      F3_B: begin
        w_be[Addr[1:0]] = 1'b1;
        w_wdat          = {4{WriteData[7:0]}};
      end
      F3_H: begin
        w_be   = Addr[1] ? 4'b1100 : 4'b0011;
        w_wdat = {2{WriteData[15:0]}};
      end
      F3_W: begin
        w_be   = 4'b1111;
        w_wdat = WriteData;
      end
      default: begin
        w_be   = 4'b0000;
        w_wdat = 32'h0;
      end
    endcase
    if (w_st_mis) w_be = 4'b0000;
  end

  // The array has no reset; reset only gates the write strobe.
  always_ff @(posedge clk) begin
    if (MemWrite && !reset) begin
      for (int i = 0; i < 4; i++) begin
        if (w_be[i]) r_mem[w_idx][8*i +: 8] <= w_wdat[8*i +: 8];
      end
    end
  end

  always_comb begin
    case (Addr[1:0])
      2'b00:   w_byte = w_word[7:0];
      2'b01:   w_byte = w_word[15:8];
      2'b10:   w_byte = w_word[23:16];
      default: w_byte = w_word[31:24];
    endcase
    w_half = Addr[1] ? w_word[31:16] : w_word[15:0];
  end

  always_comb begin
    ReadData = w_word;
    case (funct3)
      F3_B:    ReadData = {{24{w_byte[7]}}, w_byte};
      F3_H:    ReadData = {{16{w_half[15]}}, w_half};
      F3_W:    ReadData = w_word;
      F3_BU:   ReadData = {24'h0, w_byte};
      F3_HU:   ReadData = {16'h0, w_half};
      default: ReadData = w_word;
    endcase
    if (w_ld_mis) ReadData = 32'h0;
  end

endmodule

// File: tb/tb_data_mem.sv
// Directed self-checking bench for data_mem; covers both DMEM_MISALIGN_TRAP_EN builds.
module tb_data_mem;

  logic        clk;
  logic        reset;
  logic [31:0] Addr;
  logic [31:0] WriteData;
  logic        MemWrite;
  logic        MemRead;
  logic [2:0]  funct3;
  logic        ErrClear;
  logic [31:0] ReadData;
  logic        MisalignErr;
  logic [31:0] ErrAddr;

  int checks;
  int errors;

  data_mem #(.DEPTH(256)) dut (
    .clk        (clk),
    .reset      (reset),
    .Addr       (Addr),
    .WriteData  (WriteData),
    .MemWrite   (MemWrite),
    .MemRead    (MemRead),
    .funct3     (funct3),
    .ErrClear   (ErrClear),
    .ReadData   (ReadData),
    .MisalignErr(MisalignErr),
    .ErrAddr    (ErrAddr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f3);
    @(negedge clk);
    Addr = a; WriteData = d; funct3 = f3; MemWrite = 1'b1; MemRead = 1'b0;
    @(posedge clk);
    #1;
    MemWrite = 1'b0;
  endtask

  task automatic set_load(input logic [31:0] a, input logic [2:0] f3);
    @(negedge clk);
    Addr = a; funct3 = f3; MemRead = 1'b1; MemWrite = 1'b0;
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1; Addr = 0; WriteData = 0; MemWrite = 0; MemRead = 0; funct3 = 0; ErrClear = 0;
    #1;
    checks++; if (MisalignErr !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", MisalignErr); end
    checks++; if (ErrAddr !== 32'h0) begin errors++; $display("FAIL reset_erraddr: got %h want 0", ErrAddr); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_byte_loads;
    do_store(32'h10, 32'h8001FF7F, 3'b010);
    set_load(32'h10, 3'b000);
    checks++; if (ReadData !== 32'h0000007F) begin errors++; $display("FAIL lb_10: got %h want 0000007f", ReadData); end
    set_load(32'h11, 3'b000);
    checks++; if (ReadData !== 32'hFFFFFFFF) begin errors++; $display("FAIL lb_11: got %h want ffffffff", ReadData); end
    set_load(32'h11, 3'b100);
    checks++; if (ReadData !== 32'h000000FF) begin errors++; $display("FAIL lbu_11: got %h want 000000ff", ReadData); end
    set_load(32'h13, 3'b000);
    checks++; if (ReadData !== 32'hFFFFFF80) begin errors++; $display("FAIL lb_13: got %h want ffffff80", ReadData); end
    set_load(32'h10, 3'b001);
    checks++; if (ReadData !== 32'hFFFFFF7F) begin errors++; $display("FAIL lh_10: got %h want ffffff7f", ReadData); end
    set_load(32'h12, 3'b101);
    checks++; if (ReadData !== 32'h00008001) begin errors++; $display("FAIL lhu_12: got %h want 00008001", ReadData); end
  endtask

  task automatic test_half_store;
    do_store(32'h20, 32'h11223344, 3'b010);
    do_store(32'h22, 32'h0000ABCD, 3'b001);
    set_load(32'h20, 3'b010);
    checks++; if (ReadData !== 32'hABCD3344) begin errors++; $display("FAIL sh_lw_20: got %h want abcd3344", ReadData); end
    set_load(32'h22, 3'b001);
    checks++; if (ReadData !== 32'hFFFFABCD) begin errors++; $display("FAIL lh_22: got %h want ffffabcd", ReadData); end
    set_load(32'h22, 3'b101);
    checks++; if (ReadData !== 32'h0000ABCD) begin errors++; $display("FAIL lhu_22: got %h want 0000abcd", ReadData); end
  endtask

  task automatic test_byte_store;
    do_store(32'h30, 32'h00000000, 3'b010);
    do_store(32'h31, 32'h1234565A, 3'b000);
    set_load(32'h30, 3'b010);
    checks++; if (ReadData !== 32'h00005A00) begin errors++; $display("FAIL sb_31: got %h want 00005a00", ReadData); end
    do_store(32'h33, 32'h000000C3, 3'b000);
    set_load(32'h30, 3'b010);
    checks++; if (ReadData !== 32'hC3005A00) begin errors++; $display("FAIL sb_33: got %h want c3005a00", ReadData); end
  endtask

  task automatic test_other_funct3;
    do_store(32'h30, 32'hFFFFFFFF, 3'b011);
    set_load(32'h30, 3'b010);
    checks++; if (ReadData !== 32'hC3005A00) begin errors++; $display("FAIL st_f3_011: got %h want c3005a00", ReadData); end
    set_load(32'h31, 3'b011);
    checks++; if (ReadData !== 32'hC3005A00) begin errors++; $display("FAIL ld_f3_011: got %h want c3005a00", ReadData); end
    set_load(32'h33, 3'b110);
    checks++; if (ReadData !== 32'hC3005A00) begin errors++; $display("FAIL ld_f3_110: got %h want c3005a00", ReadData); end
  endtask

  task automatic test_wrap;
    do_store(32'h4, 32'h00000000, 3'b010);
    do_store(32'h404, 32'hA5A50001, 3'b010);
    set_load(32'h4, 3'b010);
    checks++; if (ReadData !== 32'hA5A50001) begin errors++; $display("FAIL wrap_404: got %h want a5a50001", ReadData); end
    set_load(32'hFFFFFC04, 3'b010);
    checks++; if (ReadData !== 32'hA5A50001) begin errors++; $display("FAIL wrap_high: got %h want a5a50001", ReadData); end
  endtask

  task automatic test_back_to_back;
    do_store(32'h60, 32'h01010101, 3'b010);
    @(negedge clk);
    Addr = 32'h60; WriteData = 32'h02020202; funct3 = 3'b010; MemWrite = 1'b1; MemRead = 1'b0;
    #1;
    checks++; if (ReadData !== 32'h01010101) begin errors++; $display("FAIL raw_before_edge: got %h want 01010101", ReadData); end
    @(posedge clk);
    #1;
    checks++; if (ReadData !== 32'h02020202) begin errors++; $display("FAIL raw_after_edge: got %h want 02020202", ReadData); end
    MemWrite = 1'b0;
  endtask

  task automatic test_reset_write_suppress;
    @(negedge clk);
    reset = 1'b1; Addr = 32'h30; WriteData = 32'h77777777; funct3 = 3'b010; MemWrite = 1'b1;
    #1;
    checks++; if (ReadData !== 32'hC3005A00) begin errors++; $display("FAIL read_in_reset: got %h want c3005a00", ReadData); end
    @(posedge clk);
    #1;
    MemWrite = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    set_load(32'h30, 3'b010);
    checks++; if (ReadData !== 32'hC3005A00) begin errors++; $display("FAIL write_in_reset: got %h want c3005a00", ReadData); end
  endtask

`ifdef DMEM_MISALIGN_TRAP_EN
  task automatic test_misalign;
    do_store(32'h40, 32'hCAFEF00D, 3'b010);
    do_store(32'h41, 32'h12345678, 3'b010);
    checks++; if (MisalignErr !== 1'b1) begin errors++; $display("FAIL sw41_err: got %b want 1", MisalignErr); end
    checks++; if (ErrAddr !== 32'h41) begin errors++; $display("FAIL sw41_addr: got %h want 00000041", ErrAddr); end
    set_load(32'h40, 3'b010);
    checks++; if (ReadData !== 32'hCAFEF00D) begin errors++; $display("FAIL sw41_nowrite: got %h want cafef00d", ReadData); end
    set_load(32'h46, 3'b010);
    checks++; if (ReadData !== 32'h0) begin errors++; $display("FAIL lw46_zero: got %h want 0", ReadData); end
    @(posedge clk); #1;
    checks++; if (ErrAddr !== 32'h41) begin errors++; $display("FAIL lw46_hold: got %h want 00000041", ErrAddr); end
    set_load(32'h53, 3'b001);
    ErrClear = 1'b1;
    @(posedge clk); #1;
    checks++; if (MisalignErr !== 1'b1) begin errors++; $display("FAIL clr_fault_err: got %b want 1", MisalignErr); end
    checks++; if (ErrAddr !== 32'h53) begin errors++; $display("FAIL clr_fault_addr: got %h want 00000053", ErrAddr); end
    MemRead = 1'b0;
    @(posedge clk); #1;
    ErrClear = 1'b0;
    checks++; if (MisalignErr !== 1'b0) begin errors++; $display("FAIL clr_err: got %b want 0", MisalignErr); end
    checks++; if (ErrAddr !== 32'h53) begin errors++; $display("FAIL clr_addr_hold: got %h want 00000053", ErrAddr); end
    set_load(32'h45, 3'b101);
    @(posedge clk); #1;
    MemRead = 1'b0;
    checks++; if (ErrAddr !== 32'h45) begin errors++; $display("FAIL lhu45_addr: got %h want 00000045", ErrAddr); end
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++; if (MisalignErr !== 1'b0 || ErrAddr !== 32'h0) begin errors++; $display("FAIL async_reset: got %b/%h want 0/0", MisalignErr, ErrAddr); end
    #2;
    reset = 1'b0;
    set_load(32'h40, 3'b010);
    MemRead = 1'b0;
    checks++; if (ReadData !== 32'hCAFEF00D) begin errors++; $display("FAIL persist: got %h want cafef00d", ReadData); end
  endtask
`else
  task automatic test_misalign;
    do_store(32'h41, 32'hDEADBEEF, 3'b010);
    set_load(32'h40, 3'b010);
    checks++; if (ReadData !== 32'hDEADBEEF) begin errors++; $display("FAIL sw41_aligned: got %h want deadbeef", ReadData); end
    checks++; if (MisalignErr !== 1'b0 || ErrAddr !== 32'h0) begin errors++; $display("FAIL no_trap: got %b/%h want 0/0", MisalignErr, ErrAddr); end
    do_store(32'h43, 32'h00001111, 3'b001);
    set_load(32'h43, 3'b010);
    checks++; if (ReadData !== 32'h1111BEEF) begin errors++; $display("FAIL sh43_aligned: got %h want 1111beef", ReadData); end
    set_load(32'h41, 3'b001);
    checks++; if (ReadData !== 32'hFFFFBEEF) begin errors++; $display("FAIL lh41_aligned: got %h want ffffbeef", ReadData); end
    ErrClear = 1'b1;
    @(posedge clk); #1;
    ErrClear = 1'b0;
    MemRead = 1'b0;
    checks++; if (MisalignErr !== 1'b0) begin errors++; $display("FAIL errclear_ignored: got %b want 0", MisalignErr); end
  endtask
`endif

  initial begin
    checks = 0;
    errors = 0;
    test_reset;
    test_byte_loads;
    test_half_store;
    test_byte_store;
    test_other_funct3;
    test_wrap;
    test_back_to_back;
    test_reset_write_suppress;
    test_misalign;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_mem.md
DATA_MEM -- requirements
Module: data_mem

Interface
REQ-001 Parameter DEPTH, default 256, number of 32-bit words; SHALL be a power of two, at least 4.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 Addr  input  32  byte address, driven from ALUResult.
REQ-005 WriteData  input  32  store data, taken from rs2.
REQ-006 MemWrite  input  1  store enable for the current cycle.
REQ-007 MemRead  input  1  load qualifier for the current cycle; used only for error detection.
REQ-008 funct3  input  3  access size and signedness, RV32I encoding.
REQ-009 ErrClear  input  1  clears the sticky error state.
REQ-010 ReadData  output  32  extended load data, consumed by the result-select stage.
REQ-011 MisalignErr  output  1  sticky misaligned-access flag.
REQ-012 ErrAddr  output  32  address of the first faulting access.

Function
REQ-013 Word index SHALL be Addr[log2(DEPTH)+1:2]; higher address bits are ignored, so addresses wrap modulo 4*DEPTH bytes.
REQ-014 Read SHALL be combinational from the array; a same-address write shows the old word until the clk edge and the new word after it.
REQ-015 Load extension:
- 000 (LB): sign-extend byte lane Addr[1:0].
- 001 (LH): sign-extend half Addr[1].
- 010 (LW): full word.
- 100 (LBU): zero-extend byte lane Addr[1:0].
- 101 (LHU): zero-extend half Addr[1].
- Any other funct3: raw word.
REQ-016 Store SHALL update only the selected lanes on the rising clk edge when MemWrite=1:
- 000 (SB): WriteData[7:0] into lane Addr[1:0].
- 001 (SH): WriteData[15:0] into half Addr[1].
- 010 (SW): all four lanes.
- Any other funct3: no write.
REQ-017 Misaligned access:
- LH, LHU and SH with Addr[0]=1.
- LW and SW with Addr[1:0]!=0.
- Qualified by MemRead for loads and MemWrite for stores.
REQ-018 ReadData SHALL be 0 during any misaligned load.
REQ-019 A misaligned store SHALL NOT modify any array lane.
REQ-020 On a misaligned access with MisalignErr=0, the next edge SHALL set MisalignErr=1 and capture Addr into ErrAddr.
REQ-021 While MisalignErr=1, ErrAddr SHALL hold; later faults SHALL NOT overwrite it.
REQ-022 ErrClear=1 SHALL clear MisalignErr on the next edge; ErrAddr holds its value.
REQ-023 If ErrClear and a new fault occur in the same cycle, the fault SHALL win: MisalignErr=1 and ErrAddr takes the new Addr.
REQ-024 MemWrite and MemRead both high in the same cycle SHALL behave as a store; error detection uses the store rules.

Reset
REQ-025 reset=1 SHALL immediately force MisalignErr=0 and ErrAddr=0, independent of clk.
REQ-026 The array SHALL NOT be reset; contents are undefined until written.
REQ-027 While reset=1, writes SHALL be suppressed; ReadData SHALL continue to reflect the array per REQ-014/015.
REQ-028 Reset asserted mid-access SHALL abort any pending error capture; no partial state remains after release.

Configuration
REQ-029 Macro DMEM_MISALIGN_TRAP_EN SHALL select misalignment handling.
- Defined: REQ-017 to REQ-023 apply.
- Undefined: Addr low bits are force-aligned per access size, so misaligned accesses complete as if aligned. LH/SH use Addr[1] with Addr[0] ignored; LW/SW ignore Addr[1:0]. MisalignErr and ErrAddr are tied to 0 and ErrClear is ignored.

Verification
REQ-030 SW Addr=0x10 WriteData=0x8001FF7F, then LB at 0x10 -> ReadData=0x0000007F; LB at 0x11 -> 0xFFFFFFFF; LBU at 0x11 -> 0x000000FF.
REQ-031 SH Addr=0x22 WriteData=0x0000ABCD over word 0x11223344 -> LW at 0x20 returns 0xABCD3344; LH at 0x22 returns 0xFFFFABCD.
REQ-032 Macro defined: SW Addr=0x41 -> word 0x40 unchanged, MisalignErr=1, ErrAddr=0x41. Then LW Addr=0x46 -> ErrAddr stays 0x41 and ReadData=0.
REQ-033 Macro defined, MisalignErr=1: ErrClear with LH Addr=0x53 in the same cycle -> MisalignErr=1, ErrAddr=0x53. Next cycle, ErrClear alone -> MisalignErr=0.
REQ-034 DEPTH=256: SW at 0x404 writes word index 1; reset pulse mid-run clears both error outputs immediately while array contents persist.
REQ-035 Macro undefined: SW Addr=0x41 data 0xDEADBEEF -> LW at 0x40 returns 0xDEADBEEF; MisalignErr stays 0.
